sram_requester: RTL and testbench

SRAM_REQUESTER -- requirements
Module: sram_requester

---
 rtl/sram_requester.sv | 135 +++++++++++++
 tb/tb_sram_requester.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_requester.sv
// sram_requester: bridges pipeline load/store requests to a single-transaction
// SRAM controller. A one-entry 8-byte read buffer serves repeated loads to the
// same block without a controller round trip; stores invalidate a matching entry.
module sram_requester #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_res,
    input  logic [31:0] Val_Rm,
    output logic [31:0] rd_data,
    output logic        freeze,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_st_val,
    input  logic [63:0] sram_read_data,
    input  logic        sram_ready
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 29;
    localparam int unsigned BLK_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_buf_valid;
    logic [TAG_W-1:0]    r_buf_tag;
    logic [BLK_W-1:0]    r_buf_data;

    logic [ADDR_W-1:0]   w_eff;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_rd_done;
    logic                w_wr_done;
    logic [31:0]         w_buf_word;
    logic [31:0]         w_sram_word;

    // Effective SRAM byte address; wraps silently below BASE_ADDR.
    assign w_eff       = ALU_res - BASE_ADDR;
    assign w_tag       = w_eff[31:3];
    assign w_hit       = MEM_R_EN & ~MEM_W_EN & r_buf_valid & (r_buf_tag == w_tag);
    assign w_rd_done   = (r_state == READ)  & sram_ready;
    assign w_wr_done   = (r_state == WRITE) & sram_ready;
    assign w_buf_word  = w_eff[2] ? r_buf_data[63:32]     : r_buf_data[31:0];
    assign w_sram_word = w_eff[2] ? sram_read_data[63:32] : sram_read_data[31:0];

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read buffer: filled on read completion, invalidated by a store to its block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (w_rd_done) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= w_tag;
            r_buf_data  <= sram_read_data;
        end else if (w_wr_done && (r_buf_tag == w_tag)) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Next-state, controller request and stall generation.
    always_comb begin
        w_next        = r_state;
        freeze        = 1'b0;
        sram_read_en  = 1'b0;
        sram_write_en = 1'b0;
        sram_addr     = '0;
        sram_st_val   = '0;
        case (r_state)
            IDLE: begin
                // Store wins when both enables are raised; the read is dropped.
                if (MEM_W_EN) begin
                    w_next = WRITE;
                    freeze = 1'b1;
                end else if (MEM_R_EN && !w_hit) begin
                    w_next = READ;
                    freeze = 1'b1;
                end
            end
            READ: begin
                sram_read_en = 1'b1;
                sram_addr    = {w_tag, 3'b000};
                if (sram_ready) begin
                    w_next = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            WRITE: begin
                sram_write_en = 1'b1;
                sram_addr     = w_eff;
                sram_st_val   = Val_Rm;
                if (sram_ready) begin
                    w_next = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Load result: buffer hit, or the completing controller block.
    always_comb begin
        rd_data = '0;
        if (w_hit) begin
            rd_data = w_buf_word;
        end else if (w_rd_done) begin
            rd_data = w_sram_word;
        end
    end

endmodule

// File: tb/tb_sram_requester.sv
// Testbench for sram_requester: stub SRAM controller plus a request-level model
// of the read buffer and memory contents.
module tb_sram_requester;

    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          STALL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_res, Val_Rm;
    logic [31:0] rd_data;
    logic        freeze;
    logic        sram_read_en, sram_write_en;
    logic [31:0] sram_addr, sram_st_val;
    logic [63:0] sram_read_data;
    logic        sram_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Stub controller state
    logic [63:0] stub_mem [16];
    logic [3:0]  cnt;
    logic        mem_init;

    // Reference model state
    logic             m_valid;
    logic [28:0]      m_tag;
    logic [63:0]      m_data;
    logic [63:0]      m_mem [bit [28:0]];

    sram_requester #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_res(ALU_res), .Val_Rm(Val_Rm),
        .rd_data(rd_data), .freeze(freeze),
        .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_addr(sram_addr), .sram_st_val(sram_st_val),
        .sram_read_data(sram_read_data), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pattern(input logic [3:0] i);
        if (i == 4'd0) return {32'd77, 32'd0};
        return {32'hA500_0000 + 32'(i) * 32'd2 + 32'd1, 32'hA500_0000 + 32'(i) * 32'd2};
    endfunction

    function automatic logic [31:0] word(input logic [63:0] d, input logic sel);
        return sel ? d[63:32] : d[31:0];
    endfunction

    function automatic logic [63:0] m_blk(input logic [28:0] tag);
        if (m_mem.exists(tag)) return m_mem[tag];
        return pattern(tag[3:0]);
    endfunction

    // Stub: ready on the 4th cycle of an asserted enable, ready whenever idle.
    assign sram_ready     = !(sram_read_en || sram_write_en) || (cnt == 4'd3);
    assign sram_read_data = stub_mem[sram_addr[6:3]];

    always @(posedge clk) begin
        cnt <= (sram_read_en || sram_write_en) ? cnt + 4'd1 : 4'd0;
        if (mem_init) begin
            for (int i = 0; i < 16; i++) stub_mem[i] <= pattern(4'(i));
        end else if (sram_write_en && sram_ready) begin
            if (sram_addr[2]) stub_mem[sram_addr[6:3]][63:32] <= sram_st_val;
            else              stub_mem[sram_addr[6:3]][31:0]  <= sram_st_val;
        end
    end

    // One request; leaves inputs asserted and returns just after the final edge.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] v, input string nm);
        logic [31:0] eff;
        logic [28:0] tag;
        logic        exp_hit;
        logic [31:0] exp_rd;
        logic [63:0] blk;
        int          stall;
        logic        done;
        eff     = a - BASE;
        tag     = eff[31:3];
        exp_hit = rd && !wr && m_valid && (m_tag == tag);
        @(negedge clk);
        MEM_R_EN = rd; MEM_W_EN = wr; ALU_res = a; Val_Rm = v;
        #1;
        if (exp_hit) begin
            exp_rd = word(m_data, eff[2]);
            n_cmp++;
            if (freeze !== 1'b0 || sram_read_en !== 1'b0 || rd_data !== exp_rd) begin
                n_err++;
                $display("FAIL %s hit: freeze=%b ren=%b rd_data=%h, required freeze=0 ren=0 rd_data=%h",
                         nm, freeze, sram_read_en, rd_data, exp_rd);
            end
            @(posedge clk);
            return;
        end
        n_cmp++;
        if (freeze !== 1'b1 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0 || sram_addr !== 32'd0) begin
            n_err++;
            $display("FAIL %s issue: freeze=%b ren=%b wen=%b addr=%h, required 1 0 0 0",
                     nm, freeze, sram_read_en, sram_write_en, sram_addr);
        end
        stall = 1;
        done  = 1'b0;
        for (int c = 1; c < 20 && !done; c++) begin
            @(negedge clk); #1;
            if (c == 1) begin
                n_cmp++;
                if (wr) begin
                    if (sram_write_en !== 1'b1 || sram_read_en !== 1'b0 || sram_addr !== eff || sram_st_val !== v) begin
                        n_err++;
                        $display("FAIL %s write_req: wen=%b ren=%b addr=%h val=%h, required 1 0 %h %h",
                                 nm, sram_write_en, sram_read_en, sram_addr, sram_st_val, eff, v);
                    end
                end else begin
                    if (sram_read_en !== 1'b1 || sram_write_en !== 1'b0 || sram_addr !== {tag, 3'b000} || rd_data !== 32'd0) begin
                        n_err++;
                        $display("FAIL %s read_req: ren=%b wen=%b addr=%h rd_data=%h, required 1 0 %h 0",
                                 nm, sram_read_en, sram_write_en, sram_addr, rd_data, {tag, 3'b000});
                    end
                end
            end
            if (freeze) stall++;
            else        done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s timeout: freeze still 1 after 20 cycles, required completion", nm);
        end else if (stall != STALL) begin
            n_err++;
            $display("FAIL %s stall: %0d cycles, required %0d", nm, stall, STALL);
        end
        if (!wr) begin
            exp_rd = word(m_blk(tag), eff[2]);
            n_cmp++;
            if (rd_data !== exp_rd) begin
                n_err++;
                $display("FAIL %s load_data: rd_data=%h, required %h", nm, rd_data, exp_rd);
            end
        end
        @(posedge clk); #1;
        if (wr) begin
            blk = m_blk(tag);
            if (eff[2]) blk[63:32] = v; else blk[31:0] = v;
            m_mem[tag] = blk;
            if (m_valid && m_tag == tag) m_valid = 1'b0;
            n_cmp++;
            if (word(stub_mem[tag[3:0]], eff[2]) !== v) begin
                n_err++;
                $display("FAIL %s stored_word: mem=%h, required %h", nm, word(stub_mem[tag[3:0]], eff[2]), v);
            end
        end else begin
            m_valid = 1'b1;
            m_tag   = tag;
            m_data  = m_blk(tag);
        end
    endtask

    task automatic idle(input string nm);
        @(negedge clk);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_res = 32'd0; Val_Rm = 32'd0;
        #1;
        n_cmp++;
        if (freeze !== 1'b0 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0 || rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL %s idle: freeze=%b ren=%b wen=%b rd_data=%h, required all 0",
                     nm, freeze, sram_read_en, sram_write_en, rd_data);
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_init = 1'b1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_res = 32'd0; Val_Rm = 32'd0;
        m_valid = 1'b0; m_tag = '0; m_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (freeze !== 1'b0 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0 ||
            sram_addr !== 32'd0 || sram_st_val !== 32'd0 || rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: freeze=%b ren=%b wen=%b addr=%h st=%h rd=%h, required all 0",
                     freeze, sram_read_en, sram_write_en, sram_addr, sram_st_val, rd_data);
        end
        MEM_R_EN = 1'b1; ALU_res = BASE;
        #1;
        n_cmp++;
        if (freeze !== 1'b1 || sram_read_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_freeze_miss: freeze=%b ren=%b, required 1 0", freeze, sram_read_en);
        end
        @(negedge clk);
        MEM_R_EN = 1'b0; ALU_res = 32'd0;
        rst = 1'b0; mem_init = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_store_load;
        do_req(1'b0, 1'b1, 32'd1024, 32'd50, "store_1024");
        idle("after_store");
        do_req(1'b1, 1'b0, 32'd1028, 32'd0, "load_1028_miss");
        idle("after_load");
        do_req(1'b1, 1'b0, 32'd1024, 32'd0, "load_1024_hit");
        idle("after_hit");
    endtask

    task automatic test_invalidate;
        do_req(1'b0, 1'b1, 32'd1028, 32'd5, "store_1028");
        idle("after_inval_store");
        do_req(1'b1, 1'b0, 32'd1024, 32'd0, "load_1024_after_inval");
        idle("after_inval_load");
    endtask

    task automatic test_both_enables;
        do_req(1'b1, 1'b1, 32'd1032, 32'h0000_0009, "both_1032");
        idle("after_both");
        do_req(1'b1, 1'b0, 32'd1028, 32'd0, "load_1028_still_hit");
        idle("after_both_hit");
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; ALU_res = 32'd1024 + 32'd40; Val_Rm = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (sram_read_en !== 1'b1) begin
            n_err++;
            $display("FAIL mid_read_active: ren=%b, required 1", sram_read_en);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sram_read_en !== 1'b0 || sram_write_en !== 1'b0 || freeze !== 1'b1) begin
            n_err++;
            $display("FAIL mid_read_reset: ren=%b wen=%b freeze=%b, required 0 0 1",
                     sram_read_en, sram_write_en, freeze);
        end
        m_valid = 1'b0;
        @(negedge clk);
        MEM_R_EN = 1'b0; ALU_res = 32'd0;
        rst = 1'b0;
        @(posedge clk);
        do_req(1'b1, 1'b0, 32'd1024 + 32'd40, 32'd0, "load_after_reset");
        idle("after_reset_load");
    endtask

    task automatic test_wrap;
        do_req(1'b1, 1'b0, 32'd1020, 32'd0, "load_wrap");
        idle("after_wrap");
        do_req(1'b1, 1'b0, 32'd1016, 32'd0, "load_wrap_hit");
        idle("after_wrap_hit");
    endtask

    task automatic test_back_to_back;
        do_req(1'b0, 1'b1, 32'd1048, 32'h1111_2222, "b2b_store");
        do_req(1'b1, 1'b0, 32'd1048, 32'd0, "b2b_load_miss");
        do_req(1'b1, 1'b0, 32'd1052, 32'd0, "b2b_load_hit");
        do_req(1'b0, 1'b1, 32'd1052, 32'h3333_4444, "b2b_store_inval");
        do_req(1'b1, 1'b0, 32'd1052, 32'd0, "b2b_reload");
        idle("after_b2b");
    endtask

    task automatic test_random;
        logic        rd, wr;
        logic [31:0] a, v;
        int          r;
        for (int k = 0; k < 60; k++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r < 6) || (r == 9);
            wr = (r >= 6);
            a  = BASE + 32'($urandom_range(0, 63));
            v  = $urandom;
            do_req(rd, wr, a, v, $sformatf("rand%0d", k));
            if ($urandom_range(0, 3) == 0) idle("rand_gap");
        end
        idle("after_rand");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_invalidate();
        test_both_enables();
        test_reset_mid_read();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
